// File: rtl/bcd_chain_counter.sv
// ---------------------------------------------------------------------------
// bcd_chain_counter
//
// Multi-digit BCD up/down counter with parallel load and a wrap or saturate
// policy at the ends of the range 0 .. 10^DIGITS-1.
//
// Parameters
//   DIGITS    number of cascaded BCD digits (1..8)
//   SATURATE  0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk    rising-edge clock
//   clr_n  synchronous active-low clear (q, cout, err -> 0)
//   en     count enable, one decimal step per cycle
//   up     direction, 1 = increment, 0 = decrement
//   load   parallel load strobe, takes priority over en
//   din    BCD load value, digit 0 in din[3:0]
//   q      current BCD count, digit 0 in q[3:0]
//   cout   registered one-cycle pulse on a wrap / overflow attempt
//   tc     combinational terminal count, en & (q at the end for direction up)
//   err    sticky flag, set when a load contained a digit above 9
// ---------------------------------------------------------------------------
module bcd_chain_counter #(
    parameter int unsigned DIGITS   = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   q,
    output logic                  cout,
    output logic                  tc,
    output logic                  err
);

    logic [4*DIGITS-1:0] cnt_q;
    logic                cout_q;
    logic                err_q;

    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_val;
    logic                load_bad;
    logic                at_end;

    // nine_below[i] / zero_below[i]: every digit below digit i is 9 / 0.
    // Entry DIGITS therefore means the whole count is all-9 / all-0.
    logic [DIGITS:0]     nine_below;
    logic [DIGITS:0]     zero_below;

    // Single-cycle carry/borrow chain and load sanitising.
    always_comb begin
        logic [3:0] d;
        logic [3:0] ld;

        d             = '0;
        ld            = '0;
        step_val      = '0;
        load_val      = '0;
        load_bad      = 1'b0;
        nine_below    = '0;
        zero_below    = '0;
        nine_below[0] = 1'b1;
        zero_below[0] = 1'b1;

        for (int unsigned i = 0; i < DIGITS; i++) begin
            d  = cnt_q[4*i +: 4];
            ld = din[4*i +: 4];

            nine_below[i+1] = nine_below[i] & (d == 4'd9);
            zero_below[i+1] = zero_below[i] & (d == 4'd0);

            step_val[4*i +: 4] = d;
            if (up) begin
                if (nine_below[i]) begin
                    step_val[4*i +: 4] = (d == 4'd9) ? 4'd0 : 4'(d + 4'd1);
                end
            end else begin
                if (zero_below[i]) begin
                    step_val[4*i +: 4] = (d == 4'd0) ? 4'd9 : 4'(d - 4'd1);
                end
            end

            // Non-decimal load digits are replaced by 0 so q stays pure BCD.
            if (ld > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_val[4*i +: 4] = ld;
            end
        end

        at_end = up ? nine_below[DIGITS] : zero_below[DIGITS];
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (load) begin
            cnt_q  <= load_val;
            cout_q <= 1'b0;
            err_q  <= err_q | load_bad;
        end else if (en) begin
            // The chain already wraps all-9 -> all-0 and all-0 -> all-9,
            // so saturation only needs to suppress the update at the end.
            cout_q <= at_end;
            if (!(SATURATE && at_end)) begin
                cnt_q <= step_val;
            end
        end else begin
            cout_q <= 1'b0;
        end
    end

    assign q    = cnt_q;
    assign cout = cout_q;
    assign err  = err_q;
    assign tc   = en & at_end;

endmodule

// File: tb/tb_bcd_chain_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_chain_counter
//
// Drives three counters from one stimulus stream: 2-digit wrap, 2-digit
// saturate and 4-digit wrap. Each is compared against an integer model of
// the decimal count (0 .. 10^D-1) converted to BCD for comparison.
// ---------------------------------------------------------------------------
module tb_bcd_chain_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr_n = 1'b1;
    logic        en    = 1'b0;
    logic        up    = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] din   = '0;

    logic [7:0]  qa, qb;
    logic [15:0] qc;
    logic        couta, coutb, coutc;
    logic        tca, tcb, tcc;
    logic        erra, errb, errc;

    bcd_chain_counter #(.DIGITS(2), .SATURATE(1'b0)) u_wrap2 (
        .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
        .din(din[7:0]), .q(qa), .cout(couta), .tc(tca), .err(erra)
    );

    bcd_chain_counter #(.DIGITS(2), .SATURATE(1'b1)) u_sat2 (
        .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
        .din(din[7:0]), .q(qb), .cout(coutb), .tc(tcb), .err(errb)
    );

    bcd_chain_counter #(.DIGITS(4), .SATURATE(1'b0)) u_wrap4 (
        .clk(clk), .clr_n(clr_n), .en(en), .up(up), .load(load),
        .din(din), .q(qc), .cout(coutc), .tc(tcc), .err(errc)
    );

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = wrap2, 1 = sat2, 2 = wrap4
    int mv[3];
    int mc[3];
    int me[3];
    bit known = 1'b0;

    function automatic int ndig(input int k);
        return (k == 2) ? 4 : 2;
    endfunction

    function automatic int maxv(input int k);
        return (k == 2) ? 9999 : 99;
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int nd);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int v, p, d;
        bit bad;
        for (int k = 0; k < 3; k++) begin
            if (!clr_n) begin
                mv[k] = 0; mc[k] = 0; me[k] = 0;
            end else if (load) begin
                v = 0; p = 1; bad = 1'b0;
                for (int i = 0; i < ndig(k); i++) begin
                    d = int'((din >> (4*i)) & 16'hF);
                    if (d > 9) begin
                        d = 0;
                        bad = 1'b1;
                    end
                    v = v + d * p;
                    p = p * 10;
                end
                mv[k] = v;
                mc[k] = 0;
                if (bad) me[k] = 1;
            end else if (en) begin
                if (up) begin
                    if (mv[k] == maxv(k)) begin
                        mc[k] = 1;
                        if (k != 1) mv[k] = 0;
                    end else begin
                        mv[k] = mv[k] + 1;
                        mc[k] = 0;
                    end
                end else begin
                    if (mv[k] == 0) begin
                        mc[k] = 1;
                        if (k != 1) mv[k] = maxv(k);
                    end else begin
                        mv[k] = mv[k] - 1;
                        mc[k] = 0;
                    end
                end
            end else begin
                mc[k] = 0;
            end
        end
    endtask

    function automatic logic exp_tc(input int k);
        return en && (up ? (mv[k] == maxv(k)) : (mv[k] == 0));
    endfunction

    // Apply inputs, check tc before the edge, clock, check registered outputs.
    task automatic step(input logic c, input logic l, input logic e,
                        input logic u, input logic [15:0] d);
        clr_n = c; load = l; en = e; up = u; din = d;
        #2;
        if (known) begin
            check("tc_wrap2", 16'(tca), 16'(exp_tc(0)));
            check("tc_sat2",  16'(tcb), 16'(exp_tc(1)));
            check("tc_wrap4", 16'(tcc), 16'(exp_tc(2)));
        end
        @(posedge clk);
        model_edge();
        if (!c) known = 1'b1;
        #1;
        if (known) begin
            check("q_wrap2",    16'(qa),    to_bcd(mv[0], 2));
            check("q_sat2",     16'(qb),    to_bcd(mv[1], 2));
            check("q_wrap4",    qc,         to_bcd(mv[2], 4));
            check("cout_wrap2", 16'(couta), 16'(mc[0]));
            check("cout_sat2",  16'(coutb), 16'(mc[1]));
            check("cout_wrap4", 16'(coutc), 16'(mc[2]));
            check("err_wrap2",  16'(erra),  16'(me[0]));
            check("err_sat2",   16'(errb),  16'(me[1]));
            check("err_wrap4",  16'(errc),  16'(me[2]));
        end
    endtask

    initial begin
        logic [15:0] rd;
        int r;

        // Reset beats a simultaneous load and count.
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);

        // Full up sweep with wrap.
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Down through zero.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0001);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);

        // Saturation at the top.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0098);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Load beats en, invalid digit sets sticky err.
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h003C);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0042);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Clear at the wrapping edge.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0099);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);

        // Carry across several digits and direction change.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0999);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h9999);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Randomised traffic biased toward nines and occasional bad digits.
        for (int n = 0; n < 800; n++) begin
            rd = '0;
            for (int i = 0; i < 4; i++) begin
                r = int'($urandom_range(0, 15));
                if (r > 11) r = 9;
                rd[4*i +: 4] = 4'(r);
            end
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-digit BCD counter, the successor to the team's two-digit ones/tens counter. It counts up or down in decimal across DIGITS cascaded BCD digits and supports parallel load and a wrap or saturate policy. It flags wrap/overflow with a registered carry pulse and rejects non-decimal load digits. It sits in timer, event-count and display-drive datapaths where a decimal value feeds a seven-segment or BCD consumer directly.

## Interface

- DIGITS, 2, number of BCD digits (1..8); counter range 0 .. 10^DIGITS-1
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends

- clk  in  1  rising-edge clock, sole clock
- clr_n  in  1  synchronous active-low reset/clear, sampled on clk rising edge
- en  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  parallel load strobe
- din  in  4*DIGITS  BCD load value, digit 0 in din[3:0]
- q  out  4*DIGITS  current BCD count, digit 0 in q[3:0]
- cout  out  1  registered one-cycle pulse on wrap/overflow attempt
- tc  out  1  combinational terminal count: en & (up ? q==all-9 : q==all-0)
- err  out  1  sticky flag: a load contained a digit > 9

## Operation

- Priority per edge: clr_n low > load > en count > hold.
- clr_n low: q = 0, cout = 0, err = 0, regardless of the other inputs.
- load: each digit i takes din[4i+3:4i] when it is ≤ 9. A digit > 9 loads as 0 and sets err. cout = 0. en is ignored that cycle.
- Count up (en=1, up=1):
  - digit 0 steps +1, 9 -> 0.
  - digit i (i>0) steps when all lower digits == 9.
- Count down (en=1, up=0):
  - digit 0 steps -1, 0 -> 9.
  - digit i steps when all lower digits == 0.
- Range end, up at all-9 or down at all-0:
  - SATURATE=0: q wraps to all-0 / all-9 and cout = 1 for that cycle.
  - SATURATE=1: q holds and cout = 1, meaning an overflow attempt.
- cout is 0 in every other cycle. It never stays high more than one cycle unless en keeps hitting the end each cycle (SATURATE=1 holding at the end).
- err clears only on clr_n low. Later valid loads do not clear it.
- up may change on any cycle; it takes effect on the next enabled step.
- Digit values > 9 can never appear on q.

## Timing

- All state updates occur on the clk rising edge. There is no asynchronous path.
- Count latency 1 cycle: en sampled high at edge N gives the new q after edge N.
- cout is registered and goes high after the same edge that wrapped q, aligned with the wrapped q value.
- tc is combinational from en, up and q. It is valid in the cycle before the edge that will wrap, so it can cascade to a following counter's en.
- Load latency 1 cycle. err rises after the loading edge.
- Reset latency 1 cycle. Outputs after the clr_n-low edge are q=0, cout=0, err=0. tc = en & ~up during reset, since q = 0.
- Reset mid-count or mid-load: clr_n wins that edge, and no cout pulse is produced.
- Carry chain is a single cycle across all DIGITS. There is no ripple delay across cycles.

## Test plan

- Reset and count, DIGITS=2: clr_n low 1 cycle, then en=1 up=1 for 100 cycles -> q steps 00,01..09,10..99,00. cout high only in the cycle q returns to 00. err=0 throughout.
- Down wrap and tc: load 01, en=1 up=0 -> q 01, 00, 99. tc high while q=00. cout high with q=99.
- Saturate, SATURATE=1: load 98, en=1 up=1 for 3 cycles -> q 99, 99, 99. cout low on the first step, high on the next two.
- Load priority and invalid digit: load=1, en=1, din=0x3C -> q=30 next cycle, err=1, cout=0. A later valid load of 0x42 -> q=42, err stays 1.
- Reset mid-operation: q=99 with en=1 up=1, clr_n low on that edge -> q=00, cout=0, err=0.
- Direction change and cascade, DIGITS=4: load 0999 up -> 1000 in one cycle. Toggle up=0 -> back to 0999. Then q=9999 up -> 0000 with cout=1.
